traffic_light_display: RTL and testbench

Reader-side companion to the traffic light controller. Consumes the controller's countdown (light_t) and one-hot lamp code (light_ctrl), which are produced in the sys_clk_1s domain. Resynchronises them into sys_clk, converts the count to BCD with a sequential double-dabble engine, and drives a 3-digit multiplexed 7-segment display plus three discrete lamp outputs. Flags illegal lamp codes.

---
 rtl/traffic_light_display.sv | 181 ++++++++++++++++++
 tb/tb_traffic_light_display.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/traffic_light_display.sv
// Display side of the traffic light: resynchronises the controller's countdown and lamp code,
// converts the count to BCD with a sequential double-dabble engine and scans three 7-segment digits.
module traffic_light_display #(
  parameter int SCAN_DIV = 50000
) (
  input  logic       sys_clk,
  input  logic       sys_rst_p,
  input  logic [7:0] light_t,
  input  logic [2:0] light_ctrl,
  output logic [6:0] seg_n,
  output logic [2:0] dig_n,
  output logic       lamp_r,
  output logic       lamp_y,
  output logic       lamp_g,
  output logic       fault,
  output logic       busy
);

  localparam int PW = $clog2(SCAN_DIV);
  localparam logic [6:0] SEG_BLANK = 7'h7F;
  localparam logic [6:0] SEG_MINUS = 7'b0111111;

  typedef enum logic [1:0] {IDLE, SHIFT, COMMIT} conv_state_t;

  function automatic logic [6:0] seg_code(input logic [3:0] d);
    case (d)
      4'd0:    return 7'b1000000;
      4'd1:    return 7'b1111001;
      4'd2:    return 7'b0100100;
      4'd3:    return 7'b0110000;
      4'd4:    return 7'b0011001;
      4'd5:    return 7'b0010010;
      4'd6:    return 7'b0000010;
      4'd7:    return 7'b1111000;
      4'd8:    return 7'b0000000;
      4'd9:    return 7'b0010000;
      default: return SEG_BLANK;
    endcase
  endfunction

  function automatic logic [3:0] add3(input logic [3:0] n);
    return (n >= 4'd5) ? n + 4'd3 : n;
  endfunction

  logic [10:0]  s1, s2, s3;
  logic [1:0]   fill;
  logic [7:0]   acc_t;
  logic [2:0]   acc_ctrl;
  logic         valid;
  logic         stable, accept, in_legal;
  conv_state_t  state, state_next;
  logic [19:0]  shreg, shreg_next, dabbled;
  logic [2:0]   iter, iter_next;
  logic [3:0]   hund, tens, ones;
  logic [PW-1:0] presc;
  logic [1:0]   idx, idx_next;
  logic         wrap;
  logic [6:0]   seg_sel;

  // NOTE: all state flops use non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge sys_clk or posedge sys_rst_p) begin
    if (sys_rst_p) begin
      s1   <= '0;
      s2   <= '0;
      s3   <= '0;
      fill <= '0;
    end else begin
      s1 <= {light_t, light_ctrl};
      s2 <= s1;
      s3 <= s2;
      if (fill != 2'd2) fill <= fill + 2'd1;
    end
  end

  // The fill count keeps the all-zero reset contents of the pipeline from being accepted.
  assign stable   = (fill == 2'd2) && (s2 == s3);
  assign accept   = stable && (!valid || (s2 != {acc_t, acc_ctrl})) && (state == IDLE);
  assign in_legal = (s2[2:0] == 3'b001) || (s2[2:0] == 3'b010) || (s2[2:0] == 3'b100);

  always_ff @(posedge sys_clk or posedge sys_rst_p) begin
    if (sys_rst_p) begin
      acc_t    <= '0;
      acc_ctrl <= '0;
      valid    <= 1'b0;
      fault    <= 1'b0;
      lamp_r   <= 1'b0;
      lamp_y   <= 1'b0;
      lamp_g   <= 1'b0;
    end else if (accept) begin
      acc_t    <= s2[10:3];
      acc_ctrl <= s2[2:0];
      valid    <= 1'b1;
      fault    <= !in_legal;
      lamp_g   <= in_legal & s2[0];
      lamp_y   <= in_legal & s2[1];
      lamp_r   <= in_legal & s2[2];
    end
  end

  assign dabbled = {add3(shreg[19:16]), add3(shreg[15:12]), add3(shreg[11:8]), shreg[7:0]};

  // NOTE: every combinational output gets a default first so no path can infer a latch.
  always_comb begin
    state_next = state;
    shreg_next = shreg;
    iter_next  = iter;
    case (state)
      IDLE: begin
        if (accept) begin
          state_next = SHIFT;
          shreg_next = {12'b0, s2[10:3]};
          iter_next  = 3'd0;
        end
      end
      SHIFT: begin
        shreg_next = {dabbled[18:0], 1'b0};
        iter_next  = iter + 3'd1;
        if (iter == 3'd7) state_next = COMMIT;
      end
      COMMIT:  state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge sys_clk or posedge sys_rst_p) begin
    if (sys_rst_p) begin
      state <= IDLE;
      shreg <= '0;
      iter  <= '0;
      hund  <= '0;
      tens  <= '0;
      ones  <= '0;
    end else begin
      state <= state_next;
      shreg <= shreg_next;
      iter  <= iter_next;
      if (state == COMMIT) begin
        hund <= shreg[19:16];
        tens <= shreg[15:12];
        ones <= shreg[11:8];
      end
    end
  end

  assign busy     = (state == SHIFT);
  assign wrap     = (presc == PW'(SCAN_DIV - 1));
  assign idx_next = (idx == 2'd2) ? 2'd0 : idx + 2'd1;

  always_comb begin
    seg_sel = SEG_BLANK;
    case (idx_next)
      2'd0:    seg_sel = seg_code(ones);
      2'd1:    seg_sel = ((hund == 4'd0) && (tens == 4'd0)) ? SEG_BLANK : seg_code(tens);
      default: seg_sel = (hund == 4'd0) ? SEG_BLANK : seg_code(hund);
    endcase
    if (fault) seg_sel = SEG_MINUS;
  end

  // Segment and digit drives are registered and only change as the scan index advances.
  always_ff @(posedge sys_clk or posedge sys_rst_p) begin
    if (sys_rst_p) begin
      presc <= '0;
      idx   <= '0;
      seg_n <= SEG_BLANK;
      dig_n <= 3'b111;
    end else if (wrap) begin
      presc <= '0;
      idx   <= idx_next;
      if (valid) begin
        seg_n <= seg_sel;
        dig_n <= ~(3'b001 << idx_next);
      end else begin
        seg_n <= SEG_BLANK;
        dig_n <= 3'b111;
      end
    end else begin
      presc <= presc + 1'b1;
    end
  end

endmodule

// File: tb/tb_traffic_light_display.sv
// Scoreboard bench for traffic_light_display: expected displays are queued on stimulus
// and compared against the scanned segments after each conversion completes.
module tb_traffic_light_display;

  localparam int SCAN_DIV = 4;

  logic       sys_clk = 1'b0;
  logic       sys_rst_p;
  logic [7:0] light_t;
  logic [2:0] light_ctrl;
  logic [6:0] seg_n;
  logic [2:0] dig_n;
  logic       lamp_r, lamp_y, lamp_g, fault, busy;

  traffic_light_display #(.SCAN_DIV(SCAN_DIV)) dut (
    .sys_clk    (sys_clk),
    .sys_rst_p  (sys_rst_p),
    .light_t    (light_t),
    .light_ctrl (light_ctrl),
    .seg_n      (seg_n),
    .dig_n      (dig_n),
    .lamp_r     (lamp_r),
    .lamp_y     (lamp_y),
    .lamp_g     (lamp_g),
    .fault      (fault),
    .busy       (busy)
  );

  always #5 sys_clk = ~sys_clk;

  typedef struct packed {
    logic [6:0] h;
    logic [6:0] tn;
    logic [6:0] o;
    logic       r;
    logic       y;
    logic       g;
    logic       flt;
  } exp_t;

  exp_t sb_q[$];
  int   n_checks = 0;
  int   n_errs   = 0;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errs++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
    end
  endtask

  function automatic logic [6:0] seg_of(input int d);
    case (d)
      0: return 7'b1000000;
      1: return 7'b1111001;
      2: return 7'b0100100;
      3: return 7'b0110000;
      4: return 7'b0011001;
      5: return 7'b0010010;
      6: return 7'b0000010;
      7: return 7'b1111000;
      8: return 7'b0000000;
      default: return 7'b0010000;
    endcase
  endfunction

  function automatic exp_t model(input int t, input logic [2:0] ctrl);
    exp_t e;
    int h, tn, o;
    h  = t / 100;
    tn = (t / 10) % 10;
    o  = t % 10;
    if (ctrl inside {3'b001, 3'b010, 3'b100}) begin
      e.flt = 1'b0;
      e.r   = ctrl[2];
      e.y   = ctrl[1];
      e.g   = ctrl[0];
      e.o   = seg_of(o);
      e.tn  = (h == 0 && tn == 0) ? 7'h7F : seg_of(tn);
      e.h   = (h == 0) ? 7'h7F : seg_of(h);
    end else begin
      e.flt = 1'b1;
      e.r   = 1'b0;
      e.y   = 1'b0;
      e.g   = 1'b0;
      e.o   = 7'b0111111;
      e.tn  = 7'b0111111;
      e.h   = 7'b0111111;
    end
    return e;
  endfunction

  task automatic apply(input int t, input logic [2:0] ctrl);
    sb_q.push_back(model(t, ctrl));
    light_t    = 8'(t);
    light_ctrl = ctrl;
  endtask

  task automatic wait_busy();
    int n = 0;
    while (!busy && n < 50) begin
      @(posedge sys_clk);
      #1;
      n++;
    end
    check("busy_rise", busy, 1'b1);
  endtask

  task automatic drain();
    int n = 0;
    while (sb_q.size() != 0 && n < 300) begin
      @(posedge sys_clk);
      n++;
    end
    check("drain_timeout", sb_q.size(), 0);
    repeat (4 * 3 * SCAN_DIV) @(posedge sys_clk);
    #1;
  endtask

  // Monitor state: written only by the negedge monitor below.
  logic       prev_busy = 1'b0;
  logic [2:0] prev_dig  = 3'b111;
  int         busy_len  = 0;
  int         dig_run   = 0;
  int         since_done = 0;
  int         n_conv    = 0;
  bit         have_cur  = 1'b0;
  exp_t       cur;

  always @(negedge sys_clk) begin
    if (sys_rst_p) begin
      prev_busy = 1'b0;
      prev_dig  = 3'b111;
      busy_len  = 0;
      dig_run   = 0;
      have_cur  = 1'b0;
    end else begin
      since_done++;
      if (busy) busy_len++;
      if (busy && !prev_busy) n_conv++;
      if (prev_busy && !busy) begin
        check("busy_len", busy_len, 8);
        busy_len = 0;
        check("commit_has_expectation", sb_q.size() != 0, 1'b1);
        if (sb_q.size() != 0) begin
          cur        = sb_q.pop_front();
          have_cur   = 1'b1;
          since_done = 0;
          check("fault", fault, cur.flt);
          check("lamps_ryg", {lamp_r, lamp_y, lamp_g}, {cur.r, cur.y, cur.g});
        end
      end
      if (have_cur && fault !== cur.flt) have_cur = 1'b0;
      if (dig_n != prev_dig) begin
        if (prev_dig != 3'b111 && dig_n != 3'b111) check("dig_hold", dig_run, SCAN_DIV);
        dig_run = 1;
        if (!(dig_n inside {3'b110, 3'b101, 3'b011, 3'b111})) check("dig_n_legal", dig_n, 3'b110);
        if (have_cur && since_done >= 2) begin
          case (dig_n)
            3'b110:  check("seg_ones", seg_n, cur.o);
            3'b101:  check("seg_tens", seg_n, cur.tn);
            3'b011:  check("seg_hund", seg_n, cur.h);
            default: ;
          endcase
        end
      end else begin
        dig_run++;
      end
      prev_dig  = dig_n;
      prev_busy = busy;
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: run did not finish, errors=%0d checks=%0d", n_errs, n_checks);
    $fatal(1, "watchdog expired");
  end

  initial begin
    int conv0;
    sys_rst_p  = 1'b1;
    light_t    = 8'd0;
    light_ctrl = 3'b000;
    repeat (3) @(posedge sys_clk);
    #1;
    check("rst_seg_n", seg_n, 7'h7F);
    check("rst_dig_n", dig_n, 3'b111);
    check("rst_lamps", {lamp_r, lamp_y, lamp_g}, 3'b000);
    check("rst_fault", fault, 1'b0);
    check("rst_busy", busy, 1'b0);

    // 20 green: ones 0, tens 2, hundreds blank
    apply(20, 3'b001);
    @(posedge sys_clk);
    #1 sys_rst_p = 1'b0;
    @(posedge sys_clk);
    #1;
    check("pre_accept_dig_n", dig_n, 3'b111);
    check("pre_accept_busy", busy, 1'b0);
    drain();
    check("lamp_g_20", lamp_g, 1'b1);

    apply(255, 3'b001);
    drain();
    apply(7, 3'b001);
    drain();

    // 17 -> 16 -> 15 while busy: 16 must be dropped
    conv0 = n_conv;
    apply(17, 3'b010);
    wait_busy();
    light_t = 8'd16;
    @(posedge sys_clk);
    #1;
    apply(15, 3'b010);
    drain();
    check("drop_conv_count", n_conv - conv0, 2);

    // illegal codes, then recovery on a legal one
    apply(15, 3'b011);
    drain();
    check("fault_011", fault, 1'b1);
    check("lamps_011", {lamp_r, lamp_y, lamp_g}, 3'b000);
    apply(42, 3'b000);
    drain();
    apply(42, 3'b111);
    drain();
    check("fault_111", fault, 1'b1);
    apply(15, 3'b100);
    drain();
    check("fault_clear", fault, 1'b0);
    check("lamp_r_100", lamp_r, 1'b1);

    // asynchronous reset in the middle of a conversion
    apply(123, 3'b001);
    wait_busy();
    repeat (3) @(posedge sys_clk);
    #2 sys_rst_p = 1'b1;
    #1;
    check("midrst_busy", busy, 1'b0);
    check("midrst_dig_n", dig_n, 3'b111);
    check("midrst_seg_n", seg_n, 7'h7F);
    check("midrst_lamps", {lamp_r, lamp_y, lamp_g}, 3'b000);
    check("midrst_fault", fault, 1'b0);
    @(posedge sys_clk);
    #2 sys_rst_p = 1'b0;
    @(posedge sys_clk);
    #1;
    check("postrst_dig_n", dig_n, 3'b111);
    drain();

    // constant input: a single conversion, display steady over several scans
    conv0 = n_conv;
    apply(14, 3'b100);
    drain();
    repeat (3 * 3 * SCAN_DIV) @(posedge sys_clk);
    #1;
    check("hold_conv_count", n_conv - conv0, 1);
    check("hold_lamp_r", lamp_r, 1'b1);

    $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
    $finish;
  end

endmodule
